// File: rtl/ir_calib_sequencer.sv
// ir_calib_sequencer: drives the 8-channel QTR measurement engine, averages white/black
// calibration passes into per-channel thresholds and publishes a line bitmap in RUN.
module ir_calib_sequencer #(
    parameter int TW       = 17,
    parameter int LOG2_NS  = 2,
    parameter int TIMEOUT  = 200000,
    parameter int SCAN_GAP = 1000
) (
    input  logic            wf_clk_i,
    input  logic            reset_i,
    input  logic            cmd_white_i,
    input  logic            cmd_black_i,
    input  logic            cmd_run_i,
    input  logic            cmd_stop_i,
    output logic            meas_start_o,
    output logic [7:0]      chan_sel_o,
    input  logic            meas_done_i,
    input  logic [8*TW-1:0] ttd_bus_i,
    output logic [7:0]      line_bits_o,
    output logic            line_valid_o,
    output logic            cal_valid_o,
    output logic [7:0]      bad_ch_o,
    output logic            err_o,
    output logic            busy_o
);
    localparam int NS = 1 << LOG2_NS;
    localparam int AW = TW + LOG2_NS;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, ACC, COMPUTE, RUN_GAP} state_t;
    typedef enum logic [1:0] {P_WHITE, P_BLACK, P_RUN} ptype_t;

    state_t             state_q;
    ptype_t             ptype_q;
    logic [AW-1:0]      acc_q  [8];
    logic [TW-1:0]      wavg_q [8];
    logic [TW-1:0]      bavg_q [8];
    logic [TW-1:0]      thr_q  [8];
    logic [8*TW-1:0]    ttd_q;
    logic [LOG2_NS:0]   cnt_q;
    logic [31:0]        tmr_q;
    logic [2:0]         ch_q;
    logic               have_w_q, have_b_q, cal_valid_q, err_q;
    logic               meas_start_q, line_valid_q;
    logic [7:0]         chan_sel_q, line_bits_q, bad_ch_q;

    logic [AW-1:0]      sum_d [8];
    logic [TW-1:0]      avg_d [8];
    logic [7:0]         line_d;
    logic [TW:0]        mid_sum;
    logic [TW-1:0]      thr_new;
    logic [LOG2_NS:0]   cnt_inc;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sum_d[i]  = acc_q[i] + AW'(ttd_q[i*TW +: TW]);
            avg_d[i]  = sum_d[i][AW-1:LOG2_NS];
            line_d[i] = (ttd_bus_i[i*TW +: TW] > thr_q[i]) & ~bad_ch_q[i];
        end
        // midpoint is formed one bit wider so white+black never wraps
        mid_sum = {1'b0, wavg_q[ch_q]} + {1'b0, bavg_q[ch_q]};
        thr_new = TW'(mid_sum >> 1);
        cnt_inc = cnt_q + 1'b1;
    end

    always_ff @(posedge wf_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            ptype_q      <= P_WHITE;
            for (int i = 0; i < 8; i++) begin
                acc_q[i]  <= '0;
                wavg_q[i] <= '0;
                bavg_q[i] <= '0;
                thr_q[i]  <= '0;
            end
            ttd_q        <= '0;
            cnt_q        <= '0;
            tmr_q        <= '0;
            ch_q         <= '0;
            have_w_q     <= 1'b0;
            have_b_q     <= 1'b0;
            cal_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            meas_start_q <= 1'b0;
            line_valid_q <= 1'b0;
            chan_sel_q   <= '0;
            line_bits_q  <= '0;
            bad_ch_q     <= '0;
        end else begin
            meas_start_q <= 1'b0;
            line_valid_q <= 1'b0;
            if (cmd_stop_i && state_q != IDLE) begin
                state_q    <= IDLE;
                chan_sel_q <= '0;
                cnt_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_stop_i) begin
                            err_q <= 1'b0;
                        end else if (cmd_white_i || cmd_black_i) begin
                            for (int i = 0; i < 8; i++) acc_q[i] <= '0;
                            cnt_q        <= '0;
                            ptype_q      <= cmd_white_i ? P_WHITE : P_BLACK;
                            err_q        <= 1'b0;
                            if (cal_valid_q) begin
                                cal_valid_q <= 1'b0;
                                if (cmd_white_i) have_w_q <= 1'b0;
                                else have_b_q <= 1'b0;
                            end
                            state_q      <= REQ;
                            meas_start_q <= 1'b1;
                            chan_sel_q   <= 8'hFF;
                        end else if (cmd_run_i && cal_valid_q) begin
                            ptype_q      <= P_RUN;
                            err_q        <= 1'b0;
                            state_q      <= REQ;
                            meas_start_q <= 1'b1;
                            chan_sel_q   <= 8'hFF;
                        end
                    end
                    REQ: begin
                        tmr_q   <= '0;
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        if (meas_done_i) begin
                            ttd_q      <= ttd_bus_i;
                            chan_sel_q <= '0;
                            state_q    <= ACC;
                            // RUN result is registered here so line_valid lands one cycle after meas_done
                            if (ptype_q == P_RUN) begin
                                line_bits_q  <= line_d;
                                line_valid_q <= 1'b1;
                            end
                        end else if (tmr_q == TIMEOUT - 1) begin
                            err_q      <= 1'b1;
                            chan_sel_q <= '0;
                            cnt_q      <= '0;
                            state_q    <= IDLE;
                        end else begin
                            tmr_q <= tmr_q + 32'd1;
                        end
                    end
                    ACC: begin
                        if (ptype_q == P_RUN) begin
                            tmr_q   <= '0;
                            state_q <= RUN_GAP;
                        end else begin
                            for (int i = 0; i < 8; i++) acc_q[i] <= sum_d[i];
                            cnt_q <= cnt_inc;
                            if (cnt_inc == (LOG2_NS+1)'(NS)) begin
                                for (int i = 0; i < 8; i++) begin
                                    if (ptype_q == P_WHITE) wavg_q[i] <= avg_d[i];
                                    else bavg_q[i] <= avg_d[i];
                                end
                                if (ptype_q == P_WHITE) have_w_q <= 1'b1;
                                else have_b_q <= 1'b1;
                                ch_q    <= '0;
                                state_q <= ((ptype_q == P_WHITE) ? have_b_q : have_w_q) ? COMPUTE : IDLE;
                            end else begin
                                state_q      <= REQ;
                                meas_start_q <= 1'b1;
                                chan_sel_q   <= 8'hFF;
                            end
                        end
                    end
                    COMPUTE: begin
                        thr_q[ch_q]    <= thr_new;
                        bad_ch_q[ch_q] <= bavg_q[ch_q] <= wavg_q[ch_q];
                        ch_q           <= ch_q + 3'd1;
                        if (ch_q == 3'd7) begin
                            cal_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    RUN_GAP: begin
                        if (tmr_q == SCAN_GAP - 1) begin
                            state_q      <= REQ;
                            meas_start_q <= 1'b1;
                            chan_sel_q   <= 8'hFF;
                        end else begin
                            tmr_q <= tmr_q + 32'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign meas_start_o = meas_start_q;
    assign chan_sel_o   = chan_sel_q;
    assign line_bits_o  = line_bits_q;
    assign line_valid_o = line_valid_q;
    assign cal_valid_o  = cal_valid_q;
    assign bad_ch_o     = bad_ch_q;
    assign err_o        = err_q;
    assign busy_o       = state_q != IDLE;
endmodule

// File: tb/tb_ir_calib_sequencer.sv
// tb_ir_calib_sequencer: directed vectors against hand-computed results, with a
// small engine responder that answers meas_start with a chosen ttd vector.
module tb_ir_calib_sequencer;
    localparam int TW  = 17;
    localparam int TO  = 40;
    localparam int GAP = 10;

    logic            clk = 1'b0, rst = 1'b1;
    logic            cw = 1'b0, cb = 1'b0, cr = 1'b0, cs = 1'b0, md = 1'b0;
    logic [8*TW-1:0] ttd = '0;
    logic            meas_start, line_valid, cal_valid, err, busy;
    logic [7:0]      chan_sel, line_bits, bad_ch;
    int              vectors = 0, miscompares = 0, ms_cnt = 0;

    ir_calib_sequencer #(.TW(TW), .LOG2_NS(2), .TIMEOUT(TO), .SCAN_GAP(GAP)) dut (
        .wf_clk_i(clk), .reset_i(rst), .cmd_white_i(cw), .cmd_black_i(cb), .cmd_run_i(cr),
        .cmd_stop_i(cs), .meas_start_o(meas_start), .chan_sel_o(chan_sel), .meas_done_i(md),
        .ttd_bus_i(ttd), .line_bits_o(line_bits), .line_valid_o(line_valid),
        .cal_valid_o(cal_valid), .bad_ch_o(bad_ch), .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (meas_start) ms_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*TW-1:0] fill(input logic [TW-1:0] v);
        logic [8*TW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*TW +: TW] = v;
        return r;
    endfunction

    function automatic logic [8*TW-1:0] put(input logic [8*TW-1:0] b, input int ch, input logic [TW-1:0] v);
        b[ch*TW +: TW] = v;
        return b;
    endfunction

    task automatic cmd(input int which);
        @(negedge clk);
        cw = (which == 0); cb = (which == 1); cr = (which == 2); cs = (which == 3);
        @(negedge clk);
        cw = 1'b0; cb = 1'b0; cr = 1'b0; cs = 1'b0;
    endtask

    task automatic wait_ms(output int n);
        n = 0;
        while (!meas_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!meas_start) check("meas_start_seen", meas_start, 1);
    endtask

    task automatic give(input logic [8*TW-1:0] v);
        @(negedge clk);
        md = 1'b1; ttd = v;
        @(negedge clk);
        md = 1'b0;
    endtask

    task automatic serve(input logic [8*TW-1:0] v);
        int n;
        wait_ms(n);
        give(v);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, ms0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {meas_start, chan_sel, line_bits, line_valid, cal_valid, bad_ch, err, busy}, 0);
        rst = 1'b0;

        // base calibration: white 100, black 900 -> thr 500
        ms_cnt = 0;
        cmd(0);
        check("busy_white", busy, 1);
        wait_ms(n);
        @(negedge clk);
        check("chan_sel_wait", chan_sel, 8'hFF);
        md = 1'b1; ttd = fill(100);
        @(negedge clk);
        md = 1'b0;
        for (int k = 0; k < 3; k++) serve(fill(100));
        wait_idle();
        check("cal_after_white", cal_valid, 0);
        cmd(1);
        for (int k = 0; k < 3; k++) serve(fill(900));
        wait_ms(n);
        @(negedge clk);
        md = 1'b1; ttd = fill(900);
        n = 0;
        do begin
            @(negedge clk);
            md = 1'b0;
            n++;
        end while (!cal_valid && n < 50);
        check("compute_latency", n, 10);
        check("cal_valid", cal_valid, 1);
        check("meas_start_count", ms_cnt, 8);
        check("bad_ch_clean", bad_ch, 8'h00);

        // run mode
        cmd(2);
        serve(put(fill(200), 3, 700));
        check("lv_latency", line_valid, 1);
        check("line_ch3", line_bits, 8'h08);
        wait_ms(n);
        check("scan_gap", n, GAP + 1);
        check("line_hold", line_bits, 8'h08);
        give(put(fill(200), 3, 500));
        check("line_eq_thr", line_bits, 8'h00);
        serve(put(fill(499), 3, 501));
        check("line_above_thr", line_bits, 8'h08);
        serve(put(fill(0), 7, 501));
        check("line_ch7", line_bits, 8'h80);
        cmd(3);
        check("stop_run", busy, 0);

        // recalibrate: black first keeps old white, then white with truncation/ch5 equality
        cmd(1);
        check("recal_clears_cv", cal_valid, 0);
        for (int k = 0; k < 4; k++) serve(put(put(fill(17'h1FFFF), 0, 203), 5, 300));
        wait_idle();
        check("cal_after_black_only", cal_valid, 1);
        cmd(0);
        for (int k = 0; k < 4; k++) serve(put(put(fill(17'h1FFFD), 0, 17'(101 + k)), 5, 300));
        wait_idle();
        check("recal_valid", cal_valid, 1);
        check("bad_ch5", bad_ch, 8'h20);
        cmd(2);
        serve(put(put(put(fill(0), 0, 152), 1, 17'h1FFFE), 5, 900));
        check("line_thr_low", line_bits, 8'h00);
        serve(put(put(put(put(fill(0), 0, 153), 1, 17'h1FFFF), 5, 900), 7, 17'h1FFFF));
        check("line_thr_high", line_bits, 8'h83);
        cmd(3);

        // timeout
        cmd(2);
        wait_ms(n);
        n = 0;
        while (!err && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_window", (n >= TO && n <= TO + 2), 1);
        check("timeout_err", err, 1);
        check("timeout_idle", busy, 0);
        check("timeout_cal_kept", cal_valid, 1);
        give(fill(900));
        check("late_done_ignored", line_valid, 0);
        cmd(0);
        check("err_cleared", err, 0);
        check("white_busy", busy, 1);

        // stop mid-pass
        serve(fill(100));
        serve(fill(100));
        cmd(3);
        check("stop_idle", busy, 0);
        ms0 = ms_cnt;
        give(fill(100));
        repeat (20) @(negedge clk);
        check("stop_no_meas", ms_cnt - ms0, 0);
        check("stop_still_idle", busy, 0);

        // reset mid-black pass
        cmd(1);
        serve(fill(900));
        wait_ms(n);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {meas_start, chan_sel, line_bits, line_valid, cal_valid, bad_ch, err, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        ms0 = ms_cnt;
        cmd(2);
        repeat (10) @(negedge clk);
        check("run_ignored_busy", busy, 0);
        check("run_ignored_meas", ms_cnt - ms0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ir_calib_sequencer.md
Name: ir_calib_sequencer

Overview:
- Sequences the 8-channel QTR reflectance measurement engine: issues measurement requests, averages samples, and derives per-channel thresholds from a white and a black calibration pass.
- In run mode it scans continuously and publishes an 8-bit line bitmap.
- Sits between the button/bump command logic and the IR measurement engine. It replaces the single global threshold with per-channel thresholds.

Parameters:
- TW, 17, width of each time-to-discharge (ttd) value.
- LOG2_NS, 2, log2 of samples averaged per calibration pass (NS = 4).
- TIMEOUT, 200000, max cycles to wait for meas_done before abort.
- SCAN_GAP, 1000, idle cycles between consecutive measurements in RUN.

Ports:
- WF_CLK  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_white  in  1  pulse: start white calibration pass
- cmd_black  in  1  pulse: start black calibration pass
- cmd_run  in  1  pulse: enter RUN (ignored unless cal_valid)
- cmd_stop  in  1  pulse: leave RUN/abort pass, go IDLE
- meas_start  out  1  one-cycle request to measurement engine
- chan_sel  out  8  channel enable to engine; 8'hFF while measuring, 8'h00 otherwise
- meas_done  in  1  one-cycle pulse; ttd_bus valid in the same cycle
- ttd_bus  in  8*TW  packed ttd, ch0 at LSBs
- line_bits  out  8  bit i = 1 when ch i reads dark (black)
- line_valid  out  1  one-cycle pulse when line_bits updates
- cal_valid  out  1  both passes done and thresholds computed
- bad_ch  out  8  bit i = 1 when ch i black_avg <= white_avg
- err  out  1  sticky timeout flag; cleared by the next accepted cmd_*
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE. All outputs 0. Accumulators, averages, thresholds and have_w/have_b flags are 0.
- States: IDLE, REQ, WAIT, ACC, COMPUTE, RUN_GAP.
- Pass type register ptype ∈ {WHITE, BLACK, RUN}.
- IDLE:
  - Command priority: cmd_stop > cmd_white > cmd_black > cmd_run.
  - cmd_white or cmd_black: clear the 8 accumulators (TW+LOG2_NS bits each) and the sample counter, set ptype, go REQ.
  - cmd_run with cal_valid=1: ptype=RUN, go REQ.
  - cmd_run with cal_valid=0: ignored.
- REQ: assert meas_start for exactly 1 cycle, chan_sel=8'hFF, load timeout counter, go WAIT.
- WAIT:
  - chan_sel held at 8'hFF.
  - meas_done: capture ttd_bus, go ACC.
  - Timeout counter hits TIMEOUT first: set err, clear ptype-related progress, go IDLE. Thresholds and cal_valid are unchanged.
- ACC:
  - WHITE/BLACK:
    - Add each channel's ttd (zero-extended) into its accumulator and increment the sample counter.
    - If counter == NS: average = acc >> LOG2_NS (TW bits, truncating), stored to white_avg[i] or black_avg[i]; set have_w or have_b.
    - If have_w and have_b are then both set, go COMPUTE; otherwise go IDLE.
    - If counter < NS: go REQ (back-to-back, no gap).
  - RUN:
    - line_bits[i] = (ttd[i] > thr[i]) & ~bad_ch[i]. A ttd equal to thr reads white.
    - Pulse line_valid in this cycle, so latency is 1 cycle after meas_done.
    - Go RUN_GAP.
- COMPUTE:
  - One channel per cycle, i = 0..7 (8 cycles).
  - thr[i] = (white_avg[i] + black_avg[i]) >> 1, computed at TW+1 bits then truncated to TW.
  - bad_ch[i] = (black_avg[i] <= white_avg[i]).
  - After ch7: cal_valid=1, go IDLE.
- RUN_GAP: count SCAN_GAP cycles, then REQ. line_bits holds its last value.
- cmd_stop:
  - In any non-IDLE state: go IDLE on the next edge. meas_start is never asserted in that cycle.
  - A meas_done arriving afterwards is ignored.
  - Mid-pass stop: accumulated samples are discarded and have_w/have_b are unchanged.
- A new cmd_white or cmd_black while cal_valid=1:
  - Clears cal_valid and the matching have_* flag.
  - Old thresholds stay until the next COMPUTE overwrites them.
- meas_done outside WAIT: ignored.
- cmd_white/black/run while busy: ignored; only cmd_stop acts.
- Any accepted cmd_* clears err.

Test Plan:
- Reset, then cmd_white with all ttd=100 (4 samples), then cmd_black with all ttd=900 -> exactly 8 meas_start pulses; COMPUTE takes 8 cycles; cal_valid=1; thr=500 on every channel; bad_ch=8'h00.
- After calibration, cmd_run with ch3=700 and others 200 -> line_valid 1 cycle after meas_done; line_bits=8'h08. Next meas_start follows SCAN_GAP+1 cycles later. ch3=500 -> bit3=0.
- White samples for ch0 of 101,102,103,104 -> white_avg=102 (truncation). Averaging must not overflow with TW-max inputs (all 17'h1FFFF -> avg 17'h1FFFF).
- Calibrate with ch5 black=white=300 -> bad_ch=8'h20; in RUN with ch5=900, line_bits[5]=0.
- Hold meas_done low after meas_start -> err=1 and state IDLE after TIMEOUT cycles; cal_valid unchanged. A following cmd_white clears err.
- Assert reset mid-black pass (sample 2 of 4) -> all outputs 0 immediately. cmd_run is then ignored because cal_valid=0. A cmd_stop mid-pass discards samples and asserts no further meas_start.
